// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, RV32I load/store
// funct3 encodings, the latched access record and the alignment helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } acc_t;

    // Size is encoded in funct3[1:0] for both signed and unsigned variants.
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        case (func3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant (mod N) wins.
// The last_grant register is owned by the caller.
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int  N   = 2,
    localparam int LGW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [LGW-1:0] last_grant,
    input  logic           enable,
    output logic [N-1:0]   grant
);

    logic           found;
    logic [LGW-1:0] idx;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = LGW'((int'(last_grant) + i) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM among N_REQ requesters, one access in flight.
// Define DMEM_ARB_ALIGN_CHK_EN to flag misaligned halfword/word accesses as errors.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MEM_WORDS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [N_REQ*3-1:0]   req_func3,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*32-1:0]  req_wdata,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 ram_we,
    output logic [2:0]           ram_func3,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);

    localparam int          LGW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    arb_state_e       state, state_next;
    logic [LGW-1:0]   last_grant, owner, grant_idx;
    logic [N_REQ-1:0] grant;
    logic             arb_en;
    acc_t             acc, sel;

    // Grants are suppressed while reset is held so req_ready is quiet during reset.
    assign arb_en = (state == IDLE) && reset;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    always_comb begin
        sel       = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = LGW'(i);
                sel.we    = req_we[i];
                sel.func3 = req_func3[i*3 +: 3];
                sel.addr  = req_addr[i*32 +: 32];
                sel.wdata = req_wdata[i*32 +: 32];
            end
        end
`ifdef DMEM_ARB_ALIGN_CHK_EN
        sel.err = (sel.addr >= ADDR_LIMIT) || misaligned(sel.func3, sel.addr[1:0]);
`else
        sel.err = (sel.addr >= ADDR_LIMIT);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    req_ready  = grant;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                ram_we     = acc.we & ~acc.err;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            owner      <= '0;
            last_grant <= LGW'(N_REQ - 1);
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && |grant) begin
                acc        <= sel;
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == ACCESS) begin
                rsp_rdata <= (acc.we || acc.err) ? 32'h0 : ram_rdata;
                rsp_err   <= acc.err;
            end
        end
    end

    assign ram_func3 = acc.func3;
    assign ram_addr  = acc.addr;
    assign ram_wdata = acc.wdata;

endmodule
